conv_window_feeder: RTL and testbench

- Producer-side front end for arithmetic_core_mod. Converts a row-major 8-bit pixel stream into packed 3x3 windows on the 72-bit `in`/`en` interface the core consumes.
- Holds two line buffers plus a 3x3 shift window, supports stride 1 or 2, and flags end of frame.
- Sits between the feature-map memory reader and the arithmetic core. `win_out`/`win_en` connect directly to the core's `in`/`en`.

---
 rtl/conv_window_feeder_if.sv | 21 ++
 rtl/conv_window_feeder.sv | 112 +++++++++++
 tb/tb_conv_window_feeder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/conv_window_feeder_if.sv
// Pixel-stream-in / window-out bundle between the feature-map reader, the
// window feeder and the arithmetic core.
interface conv_window_feeder_if;
    logic        clear;
    logic        stride;
    logic [7:0]  pix_in;
    logic        pix_en;
    logic [71:0] win_out;
    logic        win_en;
    logic        frame_done;

    modport master (
        output clear, stride, pix_in, pix_en,
        input  win_out, win_en, frame_done
    );

    modport slave (
        input  clear, stride, pix_in, pix_en,
        output win_out, win_en, frame_done
    );
endinterface

// File: rtl/conv_window_feeder.sv
// Turns a row-major 8-bit pixel stream into packed 3x3 windows using two line
// buffers and a two-column shift window; supports stride 1/2 and end-of-frame.
module conv_window_feeder #(
    parameter int unsigned IMG_W = 10,
    parameter int unsigned IMG_H = 10
) (
    input logic                  clk,
    input logic                  reset,
    conv_window_feeder_if.slave  bus
);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    logic [CW-1:0] r_col, w_col_nxt;
    logic [RW-1:0] r_row, w_row_nxt;
    logic          r_stride, w_stride_nxt;
    logic [23:0]   r_sh_a, w_sh_a_nxt;   // column c-2: {top, mid, bottom}
    logic [23:0]   r_sh_b, w_sh_b_nxt;   // column c-1: {top, mid, bottom}
    logic [71:0]   r_win_out, w_win_out_nxt;
    logic          r_win_en, w_win_en_nxt;
    logic          r_frame_done, w_frame_done_nxt;

    logic [7:0]    r_lb0 [IMG_W];
    logic [7:0]    r_lb1 [IMG_W];
    logic [7:0]    w_lb0_rd, w_lb1_rd;
    logic          w_acc, w_last_col, w_last_row, w_emit;
    logic [71:0]   w_window;

    assign w_lb0_rd   = r_lb0[r_col];
    assign w_lb1_rd   = r_lb1[r_col];
    assign w_acc      = bus.pix_en & ~bus.clear;
    assign w_last_col = (r_col == CW'(IMG_W - 1));
    assign w_last_row = (r_row == RW'(IMG_H - 1));

    // Stride 2 keeps windows whose top-left sits on an even offset from (2,2).
    assign w_emit = w_acc && (r_row >= RW'(2)) && (r_col >= CW'(2)) &&
                    (!r_stride || (!r_row[0] && !r_col[0]));

    assign w_window = {r_sh_a[23:16], r_sh_b[23:16], w_lb0_rd,
                       r_sh_a[15:8],  r_sh_b[15:8],  w_lb1_rd,
                       r_sh_a[7:0],   r_sh_b[7:0],   bus.pix_in};

    always_comb begin
        w_col_nxt        = r_col;
        w_row_nxt        = r_row;
        w_stride_nxt     = r_stride;
        w_sh_a_nxt       = r_sh_a;
        w_sh_b_nxt       = r_sh_b;
        w_win_out_nxt    = r_win_out;
        w_win_en_nxt     = 1'b0;
        w_frame_done_nxt = 1'b0;
        if (bus.clear) begin
            w_col_nxt     = '0;
            w_row_nxt     = '0;
            w_stride_nxt  = 1'b0;
            w_sh_a_nxt    = '0;
            w_sh_b_nxt    = '0;
            w_win_out_nxt = '0;
        end else if (w_acc) begin
            if (r_row == '0 && r_col == '0) begin
                w_stride_nxt = bus.stride;
            end
            if (w_last_col) begin
                w_col_nxt = '0;
                w_row_nxt = w_last_row ? '0 : r_row + RW'(1);
            end else begin
                w_col_nxt = r_col + CW'(1);
            end
            w_sh_a_nxt       = r_sh_b;
            w_sh_b_nxt       = {w_lb0_rd, w_lb1_rd, bus.pix_in};
            w_win_en_nxt     = w_emit;
            w_frame_done_nxt = w_last_col && w_last_row;
            if (w_emit) begin
                w_win_out_nxt = w_window;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col        <= '0;
            r_row        <= '0;
            r_stride     <= 1'b0;
            r_sh_a       <= '0;
            r_sh_b       <= '0;
            r_win_out    <= '0;
            r_win_en     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_stride     <= w_stride_nxt;
            r_sh_a       <= w_sh_a_nxt;
            r_sh_b       <= w_sh_b_nxt;
            r_win_out    <= w_win_out_nxt;
            r_win_en     <= w_win_en_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // Line buffers are plain RAM: every entry is rewritten before it is consumed.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb0[r_col] <= w_lb1_rd;
            r_lb1[r_col] <= bus.pix_in;
        end
    end

    assign bus.win_out    = r_win_out;
    assign bus.win_en     = r_win_en;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder: ramp frames at both strides, gapped
// input, async reset and clear mid-frame, and constant signed data.
module tb_conv_window_feeder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   fd_seen = 0;
    logic [71:0] last_win = '0;

    conv_window_feeder_if bus ();

    conv_window_feeder #(
        .IMG_W(10),
        .IMG_H(10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pixval(input int r, input int c, input int mode);
        if (mode != 0) return 8'h80;
        return 8'(10 * r + c);
    endfunction

    function automatic logic [71:0] exp_win(input int r, input int c, input int mode);
        logic [71:0] w;
        w = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w = {w[63:0], pixval(r - 2 + dr, c - 2 + dc, mode)};
        return w;
    endfunction

    // Feeds the first npix pixels of a 10x10 frame, with gaps idle cycles after each.
    task automatic feed(input bit s, input int gaps, input int mode, input int npix);
        int  k = 0;
        int  nwin = 0;
        int  idx = 0;
        bit  ee;
        bit  efd;
        logic [71:0] ew;
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 10; c++) begin
                if (idx < npix) begin
                    idx++;
                    bus.clear  = 1'b0;
                    bus.pix_en = 1'b1;
                    bus.pix_in = pixval(r, c, mode);
                    bus.stride = (r == 0 && c == 0) ? s : ~s;
                    @(posedge clk);
                    #1;
                    ee  = (r >= 2) && (c >= 2) && (!s || ((r % 2 == 0) && (c % 2 == 0)));
                    efd = (r == 9) && (c == 9);
                    if (bus.win_en === 1'b1) nwin++;
                    if (bus.frame_done === 1'b1) fd_seen++;
                    chk("win_en", 72'(bus.win_en), 72'(ee));
                    chk("frame_done", 72'(bus.frame_done), 72'(efd));
                    if (ee) begin
                        ew = exp_win(r, c, mode);
                        chk("win_out", bus.win_out, ew);
                        last_win = ew;
                        if (mode == 0 && k == 0)
                            chk("first_win", bus.win_out, 72'h0001020A0B0C141516);
                        if (mode == 0 && s && k == 1)
                            chk("second_win_s2", bus.win_out, 72'h0203040C0D0E161718);
                        if (mode == 0 && !s && efd)
                            chk("last_win", bus.win_out, 72'h4D4E4F575859616263);
                        k++;
                    end
                    for (int g = 0; g < gaps; g++) begin
                        bus.pix_en = 1'b0;
                        bus.pix_in = 8'($urandom);
                        bus.stride = 1'($urandom);
                        @(posedge clk);
                        #1;
                        chk("stall_win_en", 72'(bus.win_en), 72'(0));
                        chk("stall_hold", bus.win_out, last_win);
                        chk("stall_fd", 72'(bus.frame_done), 72'(0));
                    end
                end
            end
        end
        if (npix == 100) chk("win_count", 72'(nwin), s ? 72'd16 : 72'd64);
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_win_out"}, bus.win_out, 72'h0);
        chk({tag, "_win_en"}, 72'(bus.win_en), 72'(0));
        chk({tag, "_fd"}, 72'(bus.frame_done), 72'(0));
    endtask

    initial begin
        bus.clear  = 1'b0;
        bus.pix_en = 1'b0;
        bus.pix_in = 8'h00;
        bus.stride = 1'b0;
        #12;
        outputs_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back gapless ramps at stride 1 then stride 2.
        feed(1'b0, 0, 0, 100);
        feed(1'b1, 0, 0, 100);
        bus.pix_en = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_win_en", 72'(bus.win_en), 72'(0));

        // 1-on / 2-off input pattern must give the gapless window sequence.
        feed(1'b0, 2, 0, 100);

        // Async reset while pixel (5,3) is being presented.
        feed(1'b0, 0, 0, 53);
        bus.pix_en = 1'b1;
        bus.pix_in = 8'd53;
        #2;
        reset = 1'b0;
        #1;
        outputs_zero("async_rst");
        @(posedge clk);
        #1;
        outputs_zero("in_rst");
        @(negedge clk);
        reset = 1'b1;
        bus.pix_en = 1'b0;
        last_win = '0;
        @(posedge clk);
        #1;
        outputs_zero("post_rst");
        feed(1'b0, 0, 0, 100);

        // Clear with a coincident pixel, then two frames with stride flipped.
        feed(1'b0, 0, 0, 15);
        bus.clear  = 1'b1;
        bus.pix_en = 1'b1;
        bus.pix_in = 8'hFF;
        @(posedge clk);
        #1;
        outputs_zero("clear");
        last_win = '0;
        fd_seen = 0;
        feed(1'b0, 0, 0, 100);
        feed(1'b1, 0, 0, 100);
        chk("fd_pulses", 72'(fd_seen), 72'd2);

        // Signed constant data.
        feed(1'b0, 0, 1, 100);
        bus.pix_en = 1'b0;
        @(posedge clk);
        #1;
        chk("signed_hold", bus.win_out, 72'h808080808080808080);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
